// File: rtl/mgmt_port_config_regs_if.sv
// Byte-wide management bus between the QSPI/simulation bridge and the register file.
// The bridge (master) issues reads and writes; the register file (slave) completes reads.
interface mgmt_port_config_regs_if;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_err;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_valid, rd_data, rd_err
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_valid, rd_data, rd_err
    );
endinterface

// File: rtl/mgmt_port_config_regs.sv
// Management register file: device identity readout plus per-port VLAN/tag config
// with shadowed multi-byte commits and an update/ack handshake per port.
module mgmt_port_config_regs #(
    parameter int unsigned NUM_PORTS    = 15,
    parameter int unsigned PORT_BITS    = 4,
    parameter int unsigned REGID_BITS   = 10,
    parameter logic [15:0] IF_BASE      = 16'h4000,
    parameter int unsigned READ_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mgmt_port_config_regs_if.slave    bus,
    input  logic                      idcode_valid_i,
    input  logic [31:0]               idcode_i,
    input  logic                      die_serial_valid_i,
    input  logic [63:0]               die_serial_i,
    output logic [NUM_PORTS-1:0]      cfg_update_o,
    input  logic [NUM_PORTS-1:0]      cfg_ack_i,
    output logic [NUM_PORTS*12-1:0]   port_vlan_o,
    output logic [NUM_PORTS-1:0]      port_tagged_allowed_o,
    output logic [NUM_PORTS-1:0]      port_untagged_allowed_o,
    output logic [NUM_PORTS-1:0]      port_tag_native_o,
    output logic [NUM_PORTS-1:0]      port_tag_other_o,
    output logic [NUM_PORTS-1:0]      port_is_trunk_o
);

    localparam int unsigned CW = (READ_TIMEOUT < 2) ? 1 : $clog2(READ_TIMEOUT + 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    function automatic logic [7:0] id_byte(
        input logic [15:0] a,
        input logic [31:0] idc,
        input logic [63:0] ser
    );
        logic [2:0] sidx;
        logic [7:0] b;
        sidx = 3'(a[3:0] - 4'd4);
        b    = '0;
        if (a < 16'd4) begin
            b = 8'(idc >> {~a[1:0], 3'b000});
        end else if (a < 16'd12) begin
            b = 8'(ser >> {~sidx, 3'b000});
        end
        return b;
    endfunction

    state_e          state_q, state_d;
    logic [15:0]     raddr_q, raddr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rvalid_q, rvalid_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            rerr_q, rerr_d;

    logic [11:0]     vlan_q   [NUM_PORTS];
    logic [11:0]     vlan_d   [NUM_PORTS];
    logic [7:0]      shadow_q [NUM_PORTS];
    logic [7:0]      shadow_d [NUM_PORTS];
    logic [4:0]      tag_q    [NUM_PORTS];
    logic [4:0]      tag_d    [NUM_PORTS];
    logic [NUM_PORTS-1:0] busy_q, busy_d;
    logic [NUM_PORTS-1:0] pend_q, pend_d;
    logic [NUM_PORTS-1:0] upd_q, upd_d;
    logic [NUM_PORTS-1:0] commit, need, can;

    logic                  rd_if, wr_if;
    logic [PORT_BITS-1:0]  rd_port, wr_port;
    logic [REGID_BITS-1:0] rd_off, wr_off;
    logic                  rd_id, rd_id_ok, wait_ok;
    logic [7:0]            if_byte;

    assign rd_if   = bus.rd_addr >= IF_BASE;
    assign wr_if   = bus.wr_addr >= IF_BASE;
    assign rd_port = bus.rd_addr[REGID_BITS +: PORT_BITS];
    assign wr_port = bus.wr_addr[REGID_BITS +: PORT_BITS];
    assign rd_off  = bus.rd_addr[REGID_BITS-1:0];
    assign wr_off  = bus.wr_addr[REGID_BITS-1:0];

    assign rd_id    = bus.rd_addr < 16'd12;
    assign rd_id_ok = (bus.rd_addr < 16'd4) ? idcode_valid_i : die_serial_valid_i;
    assign wait_ok  = (raddr_q < 16'd4) ? idcode_valid_i : die_serial_valid_i;

    // Readback always reflects committed state, never the shadow byte.
    always_comb begin
        if_byte = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rd_if && int'(rd_port) == p) begin
                if (rd_off == REGID_BITS'(0)) begin
                    if_byte = vlan_q[p][7:0];
                end else if (rd_off == REGID_BITS'(1)) begin
                    if_byte = {4'h0, vlan_q[p][11:8]};
                end else if (rd_off == REGID_BITS'(2)) begin
                    if_byte = {3'b000, tag_q[p]};
                end else if (rd_off == REGID_BITS'(3)) begin
                    if_byte = {6'b0, pend_q[p], busy_q[p]};
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        raddr_d  = raddr_q;
        cnt_d    = cnt_q;
        rvalid_d = 1'b0;
        rdata_d  = '0;
        rerr_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.rd_en) begin
                    if (rd_id && !rd_id_ok) begin
                        state_d = S_WAIT;
                        raddr_d = bus.rd_addr;
                        cnt_d   = '0;
                    end else begin
                        rvalid_d = 1'b1;
                        if (rd_id) begin
                            rdata_d = id_byte(bus.rd_addr, idcode_i, die_serial_i);
                        end else begin
                            rdata_d = if_byte;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (wait_ok) begin
                    state_d  = S_IDLE;
                    rvalid_d = 1'b1;
                    rdata_d  = id_byte(raddr_q, idcode_i, die_serial_i);
                end else if (cnt_q == CW'(READ_TIMEOUT)) begin
                    state_d  = S_IDLE;
                    rvalid_d = 1'b1;
                    rerr_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        vlan_d   = vlan_q;
        shadow_d = shadow_q;
        tag_d    = tag_q;
        commit   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.wr_en && wr_if && int'(wr_port) == p) begin
                if (wr_off == REGID_BITS'(0)) begin
                    shadow_d[p] = bus.wr_data;
                end else if (wr_off == REGID_BITS'(1)) begin
                    vlan_d[p] = {bus.wr_data[3:0], shadow_q[p]};
                    commit[p] = 1'b1;
                end else if (wr_off == REGID_BITS'(2)) begin
                    tag_d[p]  = bus.wr_data[4:0];
                    commit[p] = 1'b1;
                end
            end
        end
    end

    // A commit blocked by an in-flight transfer parks in pending and goes out on ack.
    assign need = commit | pend_q;
    assign can  = ~busy_q | cfg_ack_i;

    always_comb begin
        upd_d  = '0;
        busy_d = busy_q;
        pend_d = pend_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (need[p] && can[p]) begin
                upd_d[p]  = 1'b1;
                busy_d[p] = 1'b1;
                pend_d[p] = 1'b0;
            end else if (need[p]) begin
                pend_d[p] = 1'b1;
            end else if (cfg_ack_i[p]) begin
                busy_d[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            raddr_q  <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            raddr_q  <= raddr_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                vlan_q[p]   <= '0;
                shadow_q[p] <= '0;
                tag_q[p]    <= '0;
            end
            busy_q <= '0;
            pend_q <= '0;
            upd_q  <= '0;
        end else begin
            vlan_q   <= vlan_d;
            shadow_q <= shadow_d;
            tag_q    <= tag_d;
            busy_q   <= busy_d;
            pend_q   <= pend_d;
            upd_q    <= upd_d;
        end
    end

    assign bus.rd_valid = rvalid_q;
    assign bus.rd_data  = rdata_q;
    assign bus.rd_err   = rerr_q;
    assign cfg_update_o = upd_q;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out
        assign port_vlan_o[12*g +: 12]    = vlan_q[g];
        assign port_tagged_allowed_o[g]   = tag_q[g][0];
        assign port_untagged_allowed_o[g] = tag_q[g][1];
        assign port_tag_native_o[g]       = tag_q[g][2];
        assign port_tag_other_o[g]        = tag_q[g][3];
        assign port_is_trunk_o[g]         = tag_q[g][4];
    end

endmodule
